// File: rtl/mcp3221_sample_sequencer.sv
// mcp3221_sample_sequencer
// Periodically requests a conversion from the MCP3221 I2C read core and takes in the 16-bit result
// and the per-byte ack flags. It keeps the 12-bit ADC code, drops any transaction that was not fully
// acked (counting it), and presents the result as a valid/ready sample stream.
// Optional feature macro: MCP3221_AVG_EN. When it is defined, 2^G_AVG_LOG2 good codes are averaged
// into each output sample.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   enable                          runs the periodic trigger counter
//   core_device_address             constant G_DEV_ADDR
//   core_din_valid/ready            conversion request handshake to the core
//   core_register_data[15:0]        raw read, [11:0] = ADC code
//   core_acks_received[2:0]         3'b111 = transaction fully acked
//   core_dout_valid/ready           result handshake from the core
//   sample_data/valid/ready         output sample stream
//   nack_error_count[15:0]          discarded transactions, saturating
//   overrun                         1-cycle pulse when a trigger arrives while one is already pending
module mcp3221_sample_sequencer #(
    parameter int unsigned G_SAMPLE_PERIOD = 100000,
    parameter int unsigned G_AVG_LOG2      = 2,
    parameter logic [6:0]  G_DEV_ADDR      = 7'h4D
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [6:0]  core_device_address,
    output logic        core_din_valid,
    input  logic        core_din_ready,
    input  logic [15:0] core_register_data,
    input  logic [2:0]  core_acks_received,
    input  logic        core_dout_valid,
    output logic        core_dout_ready,
    output logic [11:0] sample_data,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic [15:0] nack_error_count,
    output logic        overrun
);

    localparam int unsigned CODE_W = 12;
    localparam int unsigned PER_W  = $clog2(G_SAMPLE_PERIOD);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(G_SAMPLE_PERIOD - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_ACC, S_OUT} state_t;

    state_t              state, state_next;
    logic [PER_W-1:0]    per_cnt, per_cnt_next;
    logic                trig_pending, pending_next;
    logic [CODE_W-1:0]   code_q, code_next;
    logic [CODE_W-1:0]   sample_data_next;
    logic                sample_valid_next;
    logic                din_valid_next;
    logic                dout_ready_next;
    logic [15:0]         nack_next;
    logic                overrun_next;
    logic                wrap;
    logic                take;

    // The upper result nibble carries no ADC information.
    logic unused_hi;
    assign unused_hi = ^core_register_data[15:CODE_W];

`ifdef MCP3221_AVG_EN
    localparam int unsigned ACC_W = CODE_W + G_AVG_LOG2;
    localparam int unsigned CNT_W = (G_AVG_LOG2 > 0) ? G_AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << G_AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc, acc_next, acc_sum;
    logic [CNT_W-1:0] avg_cnt, avg_cnt_next;
`else
    localparam int unsigned unused_avg_log2 = G_AVG_LOG2;
`endif

    assign core_device_address = G_DEV_ADDR;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            per_cnt          <= '0;
            trig_pending     <= 1'b0;
            code_q           <= '0;
            sample_data      <= '0;
            sample_valid     <= 1'b0;
            core_din_valid   <= 1'b0;
            core_dout_ready  <= 1'b0;
            nack_error_count <= '0;
            overrun          <= 1'b0;
`ifdef MCP3221_AVG_EN
            acc              <= '0;
            avg_cnt          <= '0;
`endif
        end else begin
            state            <= state_next;
            per_cnt          <= per_cnt_next;
            trig_pending     <= pending_next;
            code_q           <= code_next;
            sample_data      <= sample_data_next;
            sample_valid     <= sample_valid_next;
            core_din_valid   <= din_valid_next;
            core_dout_ready  <= dout_ready_next;
            nack_error_count <= nack_next;
            overrun          <= overrun_next;
`ifdef MCP3221_AVG_EN
            acc              <= acc_next;
            avg_cnt          <= avg_cnt_next;
`endif
        end
    end

    // Trigger generation, next state and next output values
    always_comb begin
        state_next       = state;
        per_cnt_next     = per_cnt;
        pending_next     = trig_pending;
        code_next        = code_q;
        sample_data_next = sample_data;
        nack_next        = nack_error_count;
        overrun_next     = 1'b0;
`ifdef MCP3221_AVG_EN
        acc_next         = acc;
        avg_cnt_next     = avg_cnt;
        acc_sum          = acc + ACC_W'(code_q);
`endif

        wrap = enable && (per_cnt == PER_LAST);
        take = (state == S_IDLE) && trig_pending;

        if (!enable || wrap) begin
            per_cnt_next = '0;
        end else begin
            per_cnt_next = per_cnt + PER_W'(1);
        end

        // A trigger that lands while the old one is being consumed simply re-arms pending.
        if (!enable) begin
            pending_next = 1'b0;
        end else if (wrap) begin
            pending_next = 1'b1;
        end else if (take) begin
            pending_next = 1'b0;
        end
        overrun_next = wrap && trig_pending && !take;

        case (state)
            S_IDLE: begin
                if (trig_pending) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (core_din_valid && core_din_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (core_dout_valid && core_dout_ready) begin
                    if (core_acks_received == 3'b111) begin
                        code_next  = core_register_data[CODE_W-1:0];
                        state_next = S_ACC;
                    end else begin
                        if (nack_error_count != 16'hFFFF) begin
                            nack_next = nack_error_count + 16'd1;
                        end
                        state_next = S_IDLE;
                    end
                end
            end
            S_ACC: begin
`ifdef MCP3221_AVG_EN
                if (avg_cnt == CNT_LAST) begin
                    sample_data_next = CODE_W'(acc_sum >> G_AVG_LOG2);
                    acc_next         = '0;
                    avg_cnt_next     = '0;
                    state_next       = S_OUT;
                end else begin
                    acc_next     = acc_sum;
                    avg_cnt_next = avg_cnt + CNT_W'(1);
                    state_next   = S_IDLE;
                end
`else
                sample_data_next = code_q;
                state_next       = S_OUT;
`endif
            end
            S_OUT: begin
                if (sample_valid && sample_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // The handshake outputs are registered alongside the state they belong to.
        din_valid_next    = (state_next == S_REQ);
        dout_ready_next   = (state_next == S_WAIT);
        sample_valid_next = (state_next == S_OUT);
    end

endmodule

// File: tb/tb_mcp3221_sample_sequencer.sv
// Directed testbench for mcp3221_sample_sequencer with a small behavioural model of the I2C read core.
`timescale 1ns/1ps
module tb_mcp3221_sample_sequencer;

    localparam int PERIOD   = 20;
    localparam int CORE_LAT = 2;
`ifdef MCP3221_AVG_EN
    localparam int NAVG = 4;
`else
    localparam int NAVG = 1;
`endif

    logic        clk;
    logic        reset;
    logic        enable;
    logic [6:0]  core_device_address;
    logic        core_din_valid;
    logic        core_din_ready;
    logic [15:0] core_register_data;
    logic [2:0]  core_acks_received;
    logic        core_dout_valid;
    logic        core_dout_ready;
    logic [11:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic [15:0] nack_error_count;
    logic        overrun;

    mcp3221_sample_sequencer #(
        .G_SAMPLE_PERIOD(PERIOD),
        .G_AVG_LOG2     (2),
        .G_DEV_ADDR     (7'h4D)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .core_device_address(core_device_address),
        .core_din_valid     (core_din_valid),
        .core_din_ready     (core_din_ready),
        .core_register_data (core_register_data),
        .core_acks_received (core_acks_received),
        .core_dout_valid    (core_dout_valid),
        .core_dout_ready    (core_dout_ready),
        .sample_data        (sample_data),
        .sample_valid       (sample_valid),
        .sample_ready       (sample_ready),
        .nack_error_count   (nack_error_count),
        .overrun            (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks;
    int errors;

    // Response script written by the main process; the core model replays it, then defaults to 0x0ABC.
    logic [15:0] rsp_data [16];
    logic [2:0]  rsp_acks [16];
    int          rsp_len;

    // Core model: accepts requests when idle, answers CORE_LAT cycles later.
    int rsp_idx;
    int req_count;
    int wait_cnt;
    bit busy;
    bit req_hs_prev;
    bit dout_hs_prev;

    initial begin
        core_din_ready     = 1'b0;
        core_dout_valid    = 1'b0;
        core_register_data = 16'h0000;
        core_acks_received = 3'b000;
        rsp_idx = 0; req_count = 0; wait_cnt = 0;
        busy = 1'b0; req_hs_prev = 1'b0; dout_hs_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy = 1'b0; core_din_ready = 1'b0; core_dout_valid = 1'b0; rsp_idx = 0;
            end else if (req_hs_prev) begin
                busy = 1'b1; wait_cnt = CORE_LAT; core_din_ready = 1'b0; req_count++;
            end else if (dout_hs_prev) begin
                busy = 1'b0; core_dout_valid = 1'b0; core_din_ready = 1'b1; rsp_idx++;
            end else if (busy && !core_dout_valid) begin
                if (wait_cnt == 0) begin
                    core_dout_valid = 1'b1;
                    if (rsp_idx < rsp_len) begin
                        core_register_data = rsp_data[rsp_idx];
                        core_acks_received = rsp_acks[rsp_idx];
                    end else begin
                        core_register_data = 16'h0ABC;
                        core_acks_received = 3'b111;
                    end
                end else begin
                    wait_cnt--;
                end
            end else if (!busy) begin
                core_din_ready = 1'b1;
            end
            req_hs_prev  = !reset && core_din_valid && core_din_ready;
            dout_hs_prev = !reset && core_dout_valid && core_dout_ready;
        end
    end

    // Output monitor: logs every accepted sample and counts overrun pulses.
    int          cyc;
    int          samp_n;
    int          ovr_n;
    logic [11:0] samp_data [64];
    int          samp_cyc  [64];

    initial begin
        cyc = 0; samp_n = 0; ovr_n = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset && sample_valid === 1'b1 && sample_ready === 1'b1) begin
                if (samp_n < 64) begin
                    samp_data[samp_n] = sample_data;
                    samp_cyc[samp_n]  = cyc;
                end
                samp_n++;
            end
            if (overrun === 1'b1) ovr_n++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; sample_ready = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic set_rsp(input int idx, input logic [15:0] d, input logic [2:0] a);
        rsp_data[idx] = d;
        rsp_acks[idx] = a;
    endtask

    task automatic wait_samples(input int base, input int n, input int budget, output bit ok);
        int k;
        k = 0;
        while ((samp_n - base) < n && k < budget) begin
            tick(1);
            k++;
        end
        ok = ((samp_n - base) >= n);
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; sample_ready = 1'b1; rsp_len = 0;
        tick(2);
        checks++; if (core_device_address !== 7'h4D) begin errors++; $display("FAIL reset_addr: got %h expected 4d", core_device_address); end
        checks++; if (core_din_valid !== 1'b0) begin errors++; $display("FAIL reset_din_valid: got %b expected 0", core_din_valid); end
        checks++; if (core_dout_ready !== 1'b0) begin errors++; $display("FAIL reset_dout_ready: got %b expected 0", core_dout_ready); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_sample_valid: got %b expected 0", sample_valid); end
        checks++; if (sample_data !== 12'h000) begin errors++; $display("FAIL reset_sample_data: got %h expected 000", sample_data); end
        checks++; if (nack_error_count !== 16'h0000) begin errors++; $display("FAIL reset_nack: got %h expected 0000", nack_error_count); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        reset = 1'b0;
    endtask

    task automatic test_periodic();
        int base, ob;
        bit ok;
        rsp_len = 0;
        do_reset();
        base = samp_n; ob = ovr_n;
        enable = 1'b1;
        wait_samples(base, 3, 3 * PERIOD * NAVG + 40, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL periodic_timeout: got %0d samples expected 3", samp_n - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (samp_data[base + i] !== 12'hABC) begin errors++; $display("FAIL periodic_data%0d: got %h expected abc", i, samp_data[base + i]); end
            end
            checks++;
            if (samp_cyc[base + 2] - samp_cyc[base + 1] != PERIOD * NAVG) begin
                errors++; $display("FAIL periodic_interval: got %0d expected %0d", samp_cyc[base + 2] - samp_cyc[base + 1], PERIOD * NAVG);
            end
        end
        checks++; if (ovr_n - ob != 0) begin errors++; $display("FAIL periodic_overrun: got %0d expected 0", ovr_n - ob); end
        checks++; if (core_device_address !== 7'h4D) begin errors++; $display("FAIL periodic_addr: got %h expected 4d", core_device_address); end
    endtask

    // Runs the scripted responses and compares the produced samples to the expected list.
    task automatic run_script(input string name, input int n_txn, input int exp_n,
                              input logic [11:0] e0, input logic [11:0] e1,
                              input logic [11:0] e2, input logic [11:0] e3);
        int base;
        bit ok;
        logic [11:0] exp_v [4];
        exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2; exp_v[3] = e3;
        base = samp_n;
        enable = 1'b1;
        wait_samples(base, exp_n, n_txn * PERIOD + 60, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL %s_timeout: got %0d samples expected %0d", name, samp_n - base, exp_n);
        end else begin
            for (int i = 0; i < exp_n; i++) begin
                checks++;
                if (samp_data[base + i] !== exp_v[i]) begin
                    errors++; $display("FAIL %s_data%0d: got %h expected %h", name, i, samp_data[base + i], exp_v[i]);
                end
            end
        end
    endtask

    task automatic test_average();
        set_rsp(0, 16'h0100, 3'b111); set_rsp(1, 16'h0200, 3'b111);
        set_rsp(2, 16'h0300, 3'b111); set_rsp(3, 16'h0400, 3'b111);
        rsp_len = 4;
        do_reset();
`ifdef MCP3221_AVG_EN
        run_script("average", 4, 1, 12'h280, 12'h000, 12'h000, 12'h000);
`else
        run_script("average", 4, 4, 12'h100, 12'h200, 12'h300, 12'h400);
`endif
    endtask

    task automatic test_nack();
        set_rsp(0, 16'h0100, 3'b111); set_rsp(1, 16'h0999, 3'b110);
        set_rsp(2, 16'h0200, 3'b111); set_rsp(3, 16'h0300, 3'b111);
        set_rsp(4, 16'h0400, 3'b111);
        rsp_len = 5;
        do_reset();
`ifdef MCP3221_AVG_EN
        run_script("nack", 5, 1, 12'h280, 12'h000, 12'h000, 12'h000);
`else
        run_script("nack", 5, 4, 12'h100, 12'h200, 12'h300, 12'h400);
`endif
        checks++; if (nack_error_count !== 16'd1) begin errors++; $display("FAIL nack_count: got %0d expected 1", nack_error_count); end
    endtask

    task automatic test_upper_nibble();
        for (int i = 0; i < 4; i++) set_rsp(i, 16'hFABC, 3'b111);
        rsp_len = 4;
        do_reset();
        run_script("upper", 4, 1, 12'hABC, 12'h000, 12'h000, 12'h000);
    endtask

    task automatic test_backpressure();
        int k, ob, bad, rq;
        logic [11:0] held;
        rsp_len = 0;
        do_reset();
        sample_ready = 1'b0;
        enable = 1'b1;
        k = 0;
        while (sample_valid !== 1'b1 && k < NAVG * PERIOD + 60) begin tick(1); k++; end
        checks++;
        if (sample_valid !== 1'b1) begin
            errors++; $display("FAIL bp_timeout: got valid %b expected 1", sample_valid);
        end else begin
            held = sample_data; ob = ovr_n; bad = 0;
            checks++; if (held !== 12'hABC) begin errors++; $display("FAIL bp_data: got %h expected abc", held); end
            repeat (3 * PERIOD) begin
                tick(1);
                if (sample_valid !== 1'b1 || sample_data !== held) bad++;
            end
            checks++; if (bad != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", bad); end
            checks++; if (ovr_n - ob != 2) begin errors++; $display("FAIL bp_overrun: got %0d pulses expected 2", ovr_n - ob); end
            rq = req_count;
            sample_ready = 1'b1;
            tick(1);
            checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL bp_accept: got valid %b expected 0", sample_valid); end
            tick(9);
            checks++; if (req_count - rq != 1) begin errors++; $display("FAIL bp_single_pending: got %0d requests expected 1", req_count - rq); end
        end
    endtask

    task automatic test_reset_mid();
        int k, rb;
        set_rsp(0, 16'h0100, 3'b111); set_rsp(1, 16'h0200, 3'b111); set_rsp(2, 16'h0300, 3'b111);
        rsp_len = 3;
        do_reset();
        enable = 1'b1;
        rb = req_count; k = 0;
        while (!((req_count - rb) == 3 && core_dout_ready === 1'b1) && k < 3 * PERIOD + 40) begin tick(1); k++; end
        checks++;
        if (!((req_count - rb) == 3 && core_dout_ready === 1'b1)) begin
            errors++; $display("FAIL midreset_timeout: got %0d requests expected 3 in wait", req_count - rb);
        end else begin
            reset = 1'b1;
            set_rsp(0, 16'h0100, 3'b111); set_rsp(1, 16'h0200, 3'b111);
            set_rsp(2, 16'h0300, 3'b111); set_rsp(3, 16'h0400, 3'b111);
            rsp_len = 4;
            tick(1);
            checks++;
            if ({core_din_valid, core_dout_ready, sample_valid, overrun} !== 4'b0000 || sample_data !== 12'h000 || nack_error_count !== 16'h0000) begin
                errors++; $display("FAIL midreset_outputs: got %b%b%b%b data %h nack %h expected all zero",
                                   core_din_valid, core_dout_ready, sample_valid, overrun, sample_data, nack_error_count);
            end
            reset = 1'b0;
`ifdef MCP3221_AVG_EN
            run_script("midreset", 4, 1, 12'h280, 12'h000, 12'h000, 12'h000);
`else
            run_script("midreset", 4, 4, 12'h100, 12'h200, 12'h300, 12'h400);
`endif
        end
    endtask

    initial begin
        checks = 0; errors = 0; rsp_len = 0;
        reset = 1'b1; enable = 1'b0; sample_ready = 1'b1;
        test_reset();
        test_periodic();
        test_average();
        test_nack();
        test_upper_nibble();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
